instruction_cache_dm: RTL and testbench
=======================================

// Module: instruction_cache_dm
// PURPOSE
// Parametrised direct-mapped instruction cache; successor to the single-window fetch cache.
// Holds 2^LINES_LOG lines of 2^LINE_LOG bytes each, with a tag and valid bit per line.
// A 4-byte-aligned RV32I fetch that hits returns a registered instruction one cycle later.
// A miss starts a byte-serial line refill through mem_controller's icache channel; flush_in invalidates all lines.
// PARAMETERS
// LINE_LOG   4   log2 bytes per line (>=2; 16 B default)
// LINES_LOG  4   log2 number of lines (16 default)
// ADDR_W     32  fetch/memory address width
// PORTS
// clk_in      in   1       clock, rising edge
// rst_in      in   1       asynchronous reset, active-low
// req_valid   in   1       fetcher presents req_pc this cycle
// req_pc      in   ADDR_W  fetch address; [1:0]==0 required
// flush_in    in   1       invalidate all lines and abort any refill (fence.i)
// inst_out    out  32      little-endian instruction word
// pc_out      out  ADDR_W  address inst_out belongs to
// valid_out   out  1       inst_out/pc_out valid this cycle (one-cycle pulse per hit)
// mem_en      out  1       refill request to mem_controller
// miss_addr   out  ADDR_W  byte address requested
// mem_valid   in   1       miss_addr accepted this cycle; byte arrives next cycle
// mem_byte    in   8       data for the address accepted in the previous cycle
// BEHAVIOUR
// Reset (rst_in=0, async): all valid bits 0, state IDLE, valid_out=0, inst_out=0, pc_out=0,
//   mem_en=0, miss_addr=0, byte counter=0, capture flag=0. Data/tag arrays are not reset.
// Address split: offset=pc[LINE_LOG-1:0], index=pc[LINE_LOG+:LINES_LOG], tag=remaining upper bits.
// IDLE state:
//   - req_valid and hit (valid[index] && tag match): next cycle valid_out=1, pc_out=req_pc,
//     inst_out={b[off+3],b[off+2],b[off+1],b[off]}.
//   - req_valid and miss: latch line base (pc with offset bits zeroed), valid[index]<=0, cnt<=0,
//     enter REFILL; valid_out=0 next cycle.
// REFILL state:
//   - mem_en=1 and miss_addr=base+cnt until cnt reaches 2^LINE_LOG.
//   - When mem_valid=1: cnt++, capture flag set with the byte offset. The byte is written at
//     that offset in the next cycle from mem_byte.
//   - mem_valid=0: cnt holds and miss_addr is stable; no capture next cycle.
//   - After the last byte is captured: tag and valid[index] are written, then return to IDLE.
//   - The fetcher re-presents its PC and hits on the next cycle (miss-to-hit >= 2^LINE_LOG+2 cycles).
//   - valid_out=0 throughout REFILL. req_pc changes are ignored; the refill never aborts except on flush.
//   - mem_en drops in the same cycle the last address is accepted (cnt==2^LINE_LOG-1 && mem_valid).
// flush_in (any state): all valid bits <=0, state<=IDLE, mem_en<=0, in-flight byte discarded,
//   valid_out<=0. flush_in takes priority over a simultaneous hit or miss.
// Wrap-around: base+cnt never carries into the index (the counter is LINE_LOG+1 bits wide).
//   A line at the top of the address space (0xFFFF_FFF0) refills without overflowing.
// Unaligned req_pc ([1:0]!=0): treated as a miss-free no-op, valid_out=0. The fetcher never issues one.
// Reset asserted mid-refill: immediate return to reset state; the partially filled line stays invalid.
// STRUCTURE
// const_def.v: `I_CACHE_LINE_LOG, `I_CACHE_LINES_LOG defaults; `IC_IDLE / `IC_REFILL state codes.
// Sub-module icache_line_store holds the data array (2^(LINE_LOG+LINES_LOG) bytes), the tag array and the valid vector.
//   - It has one byte write port and a 4-byte read at index/offset.
//   - It has a synchronous clear-all for valid bits.
//   - The top level owns the FSM, counter and output registers.
// mem_controller remains unchanged; lsb_en priority stalls refill via mem_valid=0.
// TESTING
// 1. Cold fetch pc=0x0 with a memory model (bytes = addr[7:0]) -> mem_en, miss_addr steps 0x0..0xF;
//    a later fetch gives valid_out=1, inst_out=0x03020100.
// 2. After a fill, fetch 0x4, 0x8, 0xC on consecutive cycles -> three back-to-back hits, one-cycle latency, no mem_en.
// 3. Conflict: fill 0x000, then fetch 0x100 (same index) -> refill of 0x100..0x10F, then 0x000 misses again.
// 4. mem_valid deasserted randomly ~50% during a refill -> miss_addr held while stalled; line contents exact.
// 5. flush_in asserted at cnt=7 mid-refill -> mem_en=0 next cycle; a fetch of 0x0 refills from 0x0 again.
// 6. rst_in pulsed low mid-refill -> all outputs at reset values asynchronously; the next fetch misses.

Source files
------------

// File: rtl/instruction_cache_dm_pkg.sv
// Shared constants for the direct-mapped instruction cache.
// This package holds the default geometry, the FSM state codes and a small fetch-alignment helper.
package instruction_cache_dm_pkg;

  localparam int ICACHE_LINE_LOG_DEF  = 4;
  localparam int ICACHE_LINES_LOG_DEF = 4;
  localparam int ICACHE_ADDR_W_DEF    = 32;
  localparam int BYTES_PER_WORD       = 4;

  localparam logic [0:0] IC_IDLE   = 1'b0;
  localparam logic [0:0] IC_REFILL = 1'b1;

  function automatic logic word_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_cache_dm_line_store.sv
// Line storage for the instruction cache: byte-wide data array, tag array and valid vector.
// Read is combinational at the requested index/offset; the top level registers the result.
module instruction_cache_dm_line_store
  import instruction_cache_dm_pkg::*;
#(
  parameter int LINE_LOG  = 4,
  parameter int LINES_LOG = 4,
  parameter int TAG_W     = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_i,
  input  logic [LINES_LOG-1:0] rd_index_i,
  input  logic [LINE_LOG-1:0]  rd_offset_i,
  output logic [31:0]          rd_word_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  input  logic                 invalidate_i,
  input  logic                 byte_we_i,
  input  logic [LINES_LOG-1:0] wr_index_i,
  input  logic [LINE_LOG-1:0]  wr_offset_i,
  input  logic [7:0]           wr_byte_i,
  input  logic                 set_valid_i,
  input  logic [TAG_W-1:0]     wr_tag_i
);

  localparam int DA_W  = LINE_LOG + LINES_LOG;
  localparam int DEPTH = 1 << DA_W;
  localparam int LINES = 1 << LINES_LOG;

  logic [7:0]       data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;
  logic [DA_W-1:0]  word_base;

  // Clearing the two low bits keeps this legal even when a line is a single word.
  assign word_base = {rd_index_i, rd_offset_i} & {{(DA_W-2){1'b1}}, 2'b00};

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_rd_byte
    assign rd_word_o[8*gi +: 8] = data_mem[word_base | DA_W'(gi)];
  end

  assign rd_tag_o   = tag_mem[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

  always_ff @(posedge clk_in) begin
    if (byte_we_i) data_mem[{wr_index_i, wr_offset_i}] <= wr_byte_i;
    if (set_valid_i) tag_mem[wr_index_i] <= wr_tag_i;
  end

  // A miss invalidates the read index; completion of a refill validates the write index.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else begin
      if (invalidate_i) valid_q[rd_index_i] <= 1'b0;
      if (set_valid_i)  valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache with registered hit output and byte-serial line refill.
// The top level owns the refill FSM, byte counter, memory request and output registers.
module instruction_cache_dm
  import instruction_cache_dm_pkg::*;
#(
  parameter int LINE_LOG  = ICACHE_LINE_LOG_DEF,
  parameter int LINES_LOG = ICACHE_LINES_LOG_DEF,
  parameter int ADDR_W    = ICACHE_ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush_in,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              mem_en,
  output logic [ADDR_W-1:0] miss_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_byte
);

  localparam int TAG_W  = ADDR_W - LINE_LOG - LINES_LOG;
  localparam int LINE_W = ADDR_W - LINE_LOG;

  logic [0:0]          state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_LOG:0]   cnt_q, cnt_d, cnt_inc;
  logic                cap_q, cap_d;
  logic [LINE_LOG-1:0] cap_off_q, cap_off_d;
  logic                valid_out_q, valid_out_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;

  logic [31:0]      rd_word;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic             hit;
  logic             invalidate;
  logic             set_valid;
  logic             byte_we;

  instruction_cache_dm_line_store #(
    .LINE_LOG (LINE_LOG),
    .LINES_LOG(LINES_LOG),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_i     (flush_in),
    .rd_index_i  (req_pc[LINE_LOG +: LINES_LOG]),
    .rd_offset_i (req_pc[LINE_LOG-1:0]),
    .rd_word_o   (rd_word),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .invalidate_i(invalidate),
    .byte_we_i   (byte_we),
    .wr_index_i  (line_q[LINES_LOG-1:0]),
    .wr_offset_i (cap_off_q),
    .wr_byte_i   (mem_byte),
    .set_valid_i (set_valid),
    .wr_tag_i    (line_q[LINE_W-1 -: TAG_W])
  );

  assign hit     = rd_valid && (rd_tag == req_pc[ADDR_W-1 -: TAG_W]);
  assign cnt_inc = cnt_q + 1'b1;
  // The byte accepted last cycle lands now unless a flush discards it.
  assign byte_we = cap_q && !flush_in;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    cap_d       = 1'b0;
    cap_off_d   = cap_off_q;
    valid_out_d = 1'b0;
    inst_d      = inst_q;
    pc_d        = pc_q;
    mem_en_d    = mem_en_q;
    miss_addr_d = miss_addr_q;
    invalidate  = 1'b0;
    set_valid   = 1'b0;
    if (flush_in) begin
      state_d  = IC_IDLE;
      mem_en_d = 1'b0;
      cnt_d    = '0;
    end else if (state_q == IC_IDLE) begin
      if (req_valid && word_aligned(req_pc[1:0])) begin
        if (hit) begin
          valid_out_d = 1'b1;
          inst_d      = rd_word;
          pc_d        = req_pc;
        end else begin
          state_d     = IC_REFILL;
          line_d      = req_pc[ADDR_W-1:LINE_LOG];
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          miss_addr_d = {req_pc[ADDR_W-1:LINE_LOG], {LINE_LOG{1'b0}}};
          invalidate  = 1'b1;
        end
      end
    end else begin
      // Only the offset bits step, so the request address never carries into the index.
      if (mem_en_q && mem_valid) begin
        cnt_d       = cnt_inc;
        cap_d       = 1'b1;
        cap_off_d   = cnt_q[LINE_LOG-1:0];
        miss_addr_d = {line_q, cnt_inc[LINE_LOG-1:0]};
        if (cnt_inc[LINE_LOG]) mem_en_d = 1'b0;
      end
      if (cnt_q[LINE_LOG]) begin
        set_valid = 1'b1;
        state_d   = IC_IDLE;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IC_IDLE;
      line_q      <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      cap_off_q   <= '0;
      valid_out_q <= 1'b0;
      inst_q      <= '0;
      pc_q        <= '0;
      mem_en_q    <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_off_q   <= cap_off_d;
      valid_out_q <= valid_out_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      mem_en_q    <= mem_en_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign inst_out  = inst_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_out_q;
  assign mem_en    = mem_en_q;
  assign miss_addr = miss_addr_q;

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Scenario bench for instruction_cache_dm: byte-serial memory model, hit scoreboard and refill address checks.
module tb_instruction_cache_dm;
  localparam int ADDR_W = 32;

  logic              clk_in    = 1'b0;
  logic              rst_in    = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_pc    = '0;
  logic              flush_in  = 1'b0;
  logic              mem_valid = 1'b0;
  logic [7:0]        mem_byte  = 8'h00;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              valid_out;
  logic              mem_en;
  logic [ADDR_W-1:0] miss_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit stall_mode = 1'b0;
  logic [31:0] acc_q[$];
  logic [63:0] exp_q[$];

  instruction_cache_dm #(.LINE_LOG(4), .LINES_LOG(4), .ADDR_W(ADDR_W)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .req_valid(req_valid),
    .req_pc   (req_pc),
    .flush_in (flush_in),
    .inst_out (inst_out),
    .pc_out   (pc_out),
    .valid_out(valid_out),
    .mem_en   (mem_en),
    .miss_addr(miss_addr),
    .mem_valid(mem_valid),
    .mem_byte (mem_byte)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_fn(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [31:0] word_fn(input logic [31:0] p);
    return {mem_fn(p + 32'd3), mem_fn(p + 32'd2), mem_fn(p + 32'd1), mem_fn(p)};
  endfunction

  // Memory side: accepts miss_addr when mem_en && mem_valid, returns the byte one cycle later.
  initial begin : mem_model
    logic acc;
    logic [31:0] acc_addr;
    acc = 1'b0;
    acc_addr = '0;
    forever begin
      @(negedge clk_in);
      mem_byte  = acc ? mem_fn(acc_addr) : 8'h00;
      mem_valid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      acc       = mem_en && mem_valid && rst_in;
      acc_addr  = miss_addr;
      if (acc) acc_q.push_back(miss_addr);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    exp_q.push_back({pc, word_fn(pc)});
  endtask

  // Presents pc, reports whether a miss was signalled, then waits for the refill to finish.
  task automatic fill(input logic [31:0] pc, output bit miss_ok, output bit done);
    int cyc;
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk_in);
    req_valid = 1'b0;
    miss_ok = (mem_en === 1'b1) && (valid_out === 1'b0) && (miss_addr === {pc[31:4], 4'h0});
    cyc = 0;
    while (mem_en === 1'b1 && cyc < 400) begin
      @(negedge clk_in);
      cyc++;
    end
    done = (cyc < 400);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    #1 rst_in = 1'b0;
    #11;
    n_tests++;
    if (valid_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || mem_en !== 1'b0 || miss_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b inst=%h pc=%h mem_en=%b miss=%h, want all zero",
               valid_out, inst_out, pc_out, mem_en, miss_addr);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    acc_q.delete();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_cold_fill();
    bit miss_ok, done, bad;
    logic [63:0] e;
    acc_q.delete();
    fill(32'h0, miss_ok, done);
    n_tests++;
    if (!miss_ok || !done) begin
      n_fail++;
      $display("FAIL cold_miss: miss_ok=%0b done=%0b, want 1 1", miss_ok, done);
    end
    bad = (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'(i)) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL cold_addr_seq: %0d addresses, first=%h, want 16 from 00000000", acc_q.size(),
               acc_q.size() > 0 ? acc_q[0] : 32'hx);
    end
    acc_q.delete();
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h0;
    exp_q.push_back({32'h0, 32'h03020100});
    @(negedge clk_in);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (valid_out !== 1'b1 || pc_out !== e[63:32] || inst_out !== e[31:0]) begin
      n_fail++;
      $display("FAIL cold_hit: valid=%b pc=%h inst=%h, want 1 %h %h", valid_out, pc_out, inst_out, e[63:32], e[31:0]);
    end
    $display("[TB] cold fill 0x0: inst=%h", inst_out);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs[3] = '{32'h4, 32'h8, 32'hC};
    logic [63:0] e;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk_in);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (valid_out !== 1'b1 || pc_out !== e[63:32] || inst_out !== e[31:0] || mem_en !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_hit: valid=%b pc=%h inst=%h mem_en=%b, want 1 %h %h 0",
                   valid_out, pc_out, inst_out, mem_en, e[63:32], e[31:0]);
        end
        $display("[TB] b2b hit pc=%h inst=%h", pc_out, inst_out);
      end
      if (i < 3) issue(pcs[i]);
      else req_valid = 1'b0;
    end
    n_tests++;
    if (acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_no_refill: %0d memory accesses, want 0", acc_q.size());
    end
  endtask

  task automatic test_conflict();
    bit miss_ok, done, bad;
    logic [63:0] e;
    acc_q.delete();
    fill(32'h100, miss_ok, done);
    bad = (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'h100 + 32'(i)) bad = 1'b1;
    n_tests++;
    if (!miss_ok || !done || bad) begin
      n_fail++;
      $display("FAIL conflict_fill_100: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16 from 00000100",
               miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    @(negedge clk_in);
    issue(32'h104);
    @(negedge clk_in);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (valid_out !== 1'b1 || pc_out !== e[63:32] || inst_out !== e[31:0]) begin
      n_fail++;
      $display("FAIL conflict_hit_104: valid=%b pc=%h inst=%h, want 1 %h %h", valid_out, pc_out, inst_out, e[63:32], e[31:0]);
    end
    fill(32'h0, miss_ok, done);
    bad = (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'(i)) bad = 1'b1;
    n_tests++;
    if (!miss_ok || !done || bad) begin
      n_fail++;
      $display("FAIL conflict_evict_0: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16", miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    $display("[TB] conflict 0x100 vs 0x000 done");
  endtask

  task automatic test_stall();
    bit prev_stall, bad, timeout;
    logic [31:0] prev_addr;
    logic [31:0] pcs[4] = '{32'h230, 32'h234, 32'h238, 32'h23C};
    logic [63:0] e;
    int cyc;
    acc_q.delete();
    stall_mode = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h230;
    @(negedge clk_in);
    req_valid  = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    cyc = 0;
    while (mem_en === 1'b1 && cyc < 400) begin
      #1;
      if (prev_stall) begin
        n_tests++;
        if (miss_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL stall_hold: miss_addr=%h after stall, want %h", miss_addr, prev_addr);
        end
      end
      prev_stall = !mem_valid;
      prev_addr  = miss_addr;
      @(negedge clk_in);
      cyc++;
    end
    timeout = (cyc >= 400);
    @(negedge clk_in);
    stall_mode = 1'b0;
    bad = timeout || (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'h230 + 32'(i)) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_addr_seq: timeout=%0b addrs=%0d, want 0 16 from 00000230", timeout, acc_q.size());
    end
    acc_q.delete();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_in);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (valid_out !== 1'b1 || pc_out !== e[63:32] || inst_out !== e[31:0]) begin
          n_fail++;
          $display("FAIL stall_line_data: valid=%b pc=%h inst=%h, want 1 %h %h", valid_out, pc_out, inst_out, e[63:32], e[31:0]);
        end
        $display("[TB] stalled line hit pc=%h inst=%h", pc_out, inst_out);
      end
      if (i < 4) issue(pcs[i]);
      else req_valid = 1'b0;
    end
  endtask

  task automatic test_unaligned();
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h2;
    @(negedge clk_in);
    req_valid = 1'b0;
    n_tests++;
    if (valid_out !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL unaligned_noop: valid=%b mem_en=%b, want 0 0", valid_out, mem_en);
    end
    $display("[TB] unaligned fetch 0x2 ignored");
  endtask

  task automatic test_flush();
    bit miss_ok, done, bad;
    int cyc;
    acc_q.delete();
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h40;
    @(negedge clk_in);
    req_valid = 1'b0;
    cyc = 0;
    #1;
    while (acc_q.size() < 7 && cyc < 100) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    @(negedge clk_in);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    n_tests++;
    if (cyc >= 100 || mem_en !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort: wait=%0d mem_en=%b valid=%b, want <100 0 0", cyc, mem_en, valid_out);
    end
    acc_q.delete();
    fill(32'h0, miss_ok, done);
    bad = (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'(i)) bad = 1'b1;
    n_tests++;
    if (!miss_ok || !done || bad) begin
      n_fail++;
      $display("FAIL flush_refill_0: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16", miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    fill(32'h40, miss_ok, done);
    n_tests++;
    if (!miss_ok || !done || acc_q.size() != 16) begin
      n_fail++;
      $display("FAIL flush_partial_invalid: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16", miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h0;
    flush_in  = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b0;
    flush_in  = 1'b0;
    n_tests++;
    if (valid_out !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_priority: valid=%b mem_en=%b, want 0 0", valid_out, mem_en);
    end
    fill(32'h0, miss_ok, done);
    n_tests++;
    if (!miss_ok || !done) begin
      n_fail++;
      $display("FAIL flush_invalidates: miss_ok=%0b done=%0b, want 1 1", miss_ok, done);
    end
    acc_q.delete();
    $display("[TB] flush scenarios done");
  endtask

  task automatic test_wrap();
    bit miss_ok, done, bad;
    logic [63:0] e;
    acc_q.delete();
    fill(32'hFFFF_FFF0, miss_ok, done);
    bad = (acc_q.size() != 16);
    for (int i = 0; i < 16 && !bad; i++) if (acc_q[i] !== 32'hFFFF_FFF0 + 32'(i)) bad = 1'b1;
    n_tests++;
    if (!miss_ok || !done || bad) begin
      n_fail++;
      $display("FAIL wrap_addr_seq: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16 from fffffff0", miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    @(negedge clk_in);
    issue(32'hFFFF_FFFC);
    @(negedge clk_in);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (valid_out !== 1'b1 || pc_out !== e[63:32] || inst_out !== e[31:0]) begin
      n_fail++;
      $display("FAIL wrap_hit: valid=%b pc=%h inst=%h, want 1 %h %h", valid_out, pc_out, inst_out, e[63:32], e[31:0]);
    end
    $display("[TB] top-of-memory line hit inst=%h", inst_out);
  endtask

  task automatic test_reset_mid();
    bit miss_ok, done;
    int cyc;
    acc_q.delete();
    @(negedge clk_in);
    req_valid = 1'b1;
    req_pc    = 32'h500;
    @(negedge clk_in);
    req_valid = 1'b0;
    cyc = 0;
    #1;
    while (acc_q.size() < 5 && cyc < 100) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    #2 rst_in = 1'b0;
    #1;
    n_tests++;
    if (cyc >= 100 || valid_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || mem_en !== 1'b0 || miss_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_refill: wait=%0d valid=%b inst=%h pc=%h mem_en=%b miss=%h, want <100 and all zero",
               cyc, valid_out, inst_out, pc_out, mem_en, miss_addr);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    acc_q.delete();
    fill(32'h0, miss_ok, done);
    n_tests++;
    if (!miss_ok || !done || acc_q.size() != 16) begin
      n_fail++;
      $display("FAIL reset_then_miss: miss_ok=%0b done=%0b addrs=%0d, want 1 1 16", miss_ok, done, acc_q.size());
    end
    acc_q.delete();
    $display("[TB] reset mid-refill done");
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_back_to_back();
    test_conflict();
    test_stall();
    test_unaligned();
    test_flush();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
